// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: DEPTH valid/ready slots with global stall, flush and occupancy count.
// Define PIPE_SKID_EN to add one skid entry ahead of slot 0 (cuts the out_ready -> in_ready path).
module pipe_stage_elastic #(
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+2)-1:0] occ
);
    localparam int OCC_W = $clog2(DEPTH+2);

    logic [DEPTH-1:0]  slotVld;
    logic [DATA_W-1:0] slotData [DEPTH];
    logic [DEPTH:0]    rdy;
    logic              srcVld;
    logic [DATA_W-1:0] srcData;

    // rdy[i]: slot i may load this cycle because it is empty or its contents move on
    always_comb begin
        rdy = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = ~slotVld[i] | rdy[i+1];
        end
    end

`ifdef PIPE_SKID_EN
    logic              skidVld;
    logic [DATA_W-1:0] skidData;

    // A parked skid beat always has priority for slot 0 over the input port
    assign srcVld   = skidVld | in_valid;
    assign srcData  = skidVld ? skidData : in_data;
    assign in_ready = ~skidVld & ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            skidVld  <= 1'b0;
            skidData <= RESET_VAL;
        end else if (!stall) begin
            if (skidVld) begin
                if (rdy[0]) begin
                    skidVld <= 1'b0;
                end
            end else if (in_valid && !rdy[0]) begin
                skidVld  <= 1'b1;
                skidData <= in_data;
            end
        end
    end
`else
    assign srcVld   = in_valid;
    assign srcData  = in_data;
    assign in_ready = rdy[0] & ~stall & ~flush;
`endif

    assign out_valid = slotVld[DEPTH-1] & ~stall;
    assign out_data  = slotData[DEPTH-1];

    // Payload only changes on a valid load, so an empty slot keeps its last data
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            slotVld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slotData[i] <= RESET_VAL;
            end
        end else if (!stall) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                if (rdy[i]) begin
                    slotVld[i] <= slotVld[i-1];
                    if (slotVld[i-1]) begin
                        slotData[i] <= slotData[i-1];
                    end
                end
            end
            if (rdy[0]) begin
                slotVld[0] <= srcVld;
                if (srcVld) begin
                    slotData[0] <= srcData;
                end
            end
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(slotVld[i]);
        end
`ifdef PIPE_SKID_EN
        occ = occ + OCC_W'(skidVld);
`endif
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: DEPTH 1/2/3 instances on shared stimulus, directed scenarios
// plus randomized traffic against a queue-of-beats reference model.
module tb_pipe_stage_elastic;
    localparam int W = 16;
    localparam int DEP [3] = '{1, 2, 3};
    localparam logic [W-1:0] RVA [3] = '{16'h00A5, 16'hDEAD, 16'h0000};
`ifdef PIPE_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif

    logic clk = 1'b0;
    logic resetn, stall, flush, inValid, outReady;
    logic [W-1:0] inData;
    logic [2:0] ir, ov;
    logic [W-1:0] od [3];
    logic [1:0] occ1, occ2;
    logic [2:0] occ3;
    logic [3:0] occA [3];

    int errors = 0;
    int checks = 0;

    // Reference model: per instance a list of beats (oldest first) with their slot position;
    // position -1 means parked in the skid entry, position DEPTH means it has left.
    int mCnt [3];
    int mPos [3][8];
    int nPos [3][8];
    int tailLim [3];
    logic [W-1:0] mDat [3][8];
    logic [W-1:0] mOut [3];
    logic eIr [3];
    logic eOv [3];

    assign occA[0] = {2'b00, occ1};
    assign occA[1] = {2'b00, occ2};
    assign occA[2] = {1'b0, occ3};

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(W), .DEPTH(1), .RESET_VAL(16'h00A5)) dut1 (
        .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
        .in_valid(inValid), .in_ready(ir[0]), .in_data(inData),
        .out_valid(ov[0]), .out_ready(outReady), .out_data(od[0]), .occ(occ1));

    pipe_stage_elastic #(.DATA_W(W), .DEPTH(2), .RESET_VAL(16'hDEAD)) dut2 (
        .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
        .in_valid(inValid), .in_ready(ir[1]), .in_data(inData),
        .out_valid(ov[1]), .out_ready(outReady), .out_data(od[1]), .occ(occ2));

    pipe_stage_elastic #(.DATA_W(W), .DEPTH(3), .RESET_VAL(16'h0000)) dut3 (
        .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
        .in_valid(inValid), .in_ready(ir[2]), .in_data(inData),
        .out_valid(ov[2]), .out_ready(outReady), .out_data(od[2]), .occ(occ3));

    task automatic predict();
        for (int k = 0; k < 3; k++) begin
            int lim;
            lim = outReady ? DEP[k] + 1 : DEP[k];
            eOv[k] = (mCnt[k] > 0) && (mPos[k][0] == DEP[k] - 1) && !stall;
            for (int j = 0; j < mCnt[k]; j++) begin
                nPos[k][j] = (mPos[k][j] + 1 < lim - 1) ? mPos[k][j] + 1 : lim - 1;
                lim = nPos[k][j];
            end
            tailLim[k] = lim;
`ifdef PIPE_SKID_EN
            eIr[k] = !stall && !flush && !(mCnt[k] > 0 && mPos[k][mCnt[k] - 1] < 0);
`else
            eIr[k] = !stall && !flush && (lim > 0);
`endif
        end
    endtask

    task automatic advance();
        for (int k = 0; k < 3; k++) begin
            if (!resetn || flush) begin
                mCnt[k] = 0;
                mOut[k] = RVA[k];
            end else if (!stall) begin
                for (int j = 0; j < mCnt[k]; j++) begin
                    mPos[k][j] = nPos[k][j];
                    if (nPos[k][j] == DEP[k] - 1) mOut[k] = mDat[k][j];
                end
                if (inValid && eIr[k]) begin
                    int np;
                    np = (tailLim[k] - 1 < 0) ? tailLim[k] - 1 : 0;
                    mDat[k][mCnt[k]] = inData;
                    mPos[k][mCnt[k]] = np;
                    mCnt[k]++;
                    if (np == DEP[k] - 1) mOut[k] = inData;
                end
                if (mCnt[k] > 0 && mPos[k][0] == DEP[k]) begin
                    for (int j = 1; j < mCnt[k]; j++) begin
                        mPos[k][j-1] = mPos[k][j];
                        mDat[k][j-1] = mDat[k][j];
                    end
                    mCnt[k]--;
                end
            end
        end
    endtask

    task automatic setIn(input logic rn, input logic st, input logic fl, input logic iv,
                         input logic [W-1:0] id, input logic ordy);
        resetn = rn; stall = st; flush = fl; inValid = iv; inData = id; outReady = ordy;
        #1;
        predict();
    endtask

    task automatic tick();
        advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (6) begin
            setIn(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
            tick();
        end
    endtask

    task automatic test_reset();
        setIn(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        tick();
        setIn(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (occA[k] !== 4'd0) begin errors++; $display("FAIL reset_occ[%0d]: got %0d want 0", k, occA[k]); end
            checks++;
            if (ov[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, ov[k]); end
            checks++;
            if (od[k] !== RVA[k]) begin errors++; $display("FAIL reset_out_data[%0d]: got %h want %h", k, od[k], RVA[k]); end
            checks++;
            if (ir[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, ir[k]); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] beats [3] = '{16'h0A0A, 16'h0B0B, 16'h0C0C};
        for (int c = 0; c < 5; c++) begin
            setIn(1'b1, 1'b0, 1'b0, c < 3, beats[(c < 3) ? c : 0], 1'b1);
            if (c < 3) begin
                checks++;
                if (ir[0] !== 1'b1) begin errors++; $display("FAIL b2b_in_ready c%0d: got %b want 1", c, ir[0]); end
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (ov[0] !== 1'b1 || od[0] !== beats[c-1]) begin
                    errors++; $display("FAIL b2b_out c%0d: got v=%b d=%h want v=1 d=%h", c, ov[0], od[0], beats[c-1]);
                end
                checks++;
                if (occA[0] !== 4'd1) begin errors++; $display("FAIL b2b_occ c%0d: got %0d want 1", c, occA[0]); end
            end
            if (c == 4) begin
                checks++;
                if (ov[0] !== 1'b0 || occA[0] !== 4'd0) begin
                    errors++; $display("FAIL b2b_empty: got v=%b occ=%0d want v=0 occ=0", ov[0], occA[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] src [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        logic [W-1:0] got [4];
        int sent = 0;
        int nGot = 0;
        for (int c = 0; c < 5; c++) begin
            setIn(1'b1, 1'b0, 1'b0, sent < 4, src[(sent < 4) ? sent : 3], 1'b0);
            if (sent < 4 && ir[2]) sent++;
            tick();
        end
        setIn(1'b1, 1'b0, 1'b0, sent < 4, src[(sent < 4) ? sent : 3], 1'b0);
        checks++;
        if (occA[2] !== 4'(3 + SKID)) begin errors++; $display("FAIL bp_occ: got %0d want %0d", occA[2], 3 + SKID); end
        checks++;
        if (ir[2] !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", ir[2]); end
        checks++;
        if (ov[2] !== 1'b1 || od[2] !== 16'h0011) begin
            errors++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=0011", ov[2], od[2]);
        end
        tick();
        for (int c = 0; c < 12; c++) begin
            setIn(1'b1, 1'b0, 1'b0, sent < 4, src[(sent < 4) ? sent : 3], 1'b1);
            if (ov[2] && nGot < 4) begin got[nGot] = od[2]; nGot++; end
            if (sent < 4 && ir[2]) sent++;
            tick();
        end
        checks++;
        if (nGot !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", nGot); end
        for (int i = 0; i < nGot; i++) begin
            checks++;
            if (got[i] !== src[i]) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], src[i]); end
        end
    endtask

    task automatic test_stall();
        setIn(1'b1, 1'b0, 1'b0, 1'b1, 16'h0055, 1'b0);
        tick();
        setIn(1'b1, 1'b0, 1'b0, 1'b1, 16'h0066, 1'b0);
        checks++;
        if (ir[1] !== 1'b1) begin errors++; $display("FAIL stall_fill_ready: got %b want 1", ir[1]); end
        tick();
        for (int c = 0; c < 2; c++) begin
            setIn(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (ov[1] !== 1'b0 || ir[1] !== 1'b0) begin
                errors++; $display("FAIL stall_hs c%0d: got v=%b rdy=%b want 0 0", c, ov[1], ir[1]);
            end
            checks++;
            if (occA[1] !== 4'd2 || od[1] !== 16'h0055) begin
                errors++; $display("FAIL stall_hold c%0d: got occ=%0d d=%h want occ=2 d=0055", c, occA[1], od[1]);
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            setIn(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (c < 2 && (ov[1] !== 1'b1 || od[1] !== ((c == 0) ? 16'h0055 : 16'h0066))) begin
                errors++; $display("FAIL stall_release c%0d: got v=%b d=%h", c, ov[1], od[1]);
            end else if (c == 2 && ov[1] !== 1'b0) begin
                errors++; $display("FAIL stall_release_end: got v=%b want 0", ov[1]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        setIn(1'b1, 1'b0, 1'b0, 1'b1, 16'h0077, 1'b0);
        tick();
        setIn(1'b1, 1'b0, 1'b0, 1'b1, 16'h0088, 1'b0);
        tick();
        setIn(1'b1, 1'b1, 1'b1, 1'b1, 16'h0099, 1'b0);
        checks++;
        if (ir[1] !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", ir[1]); end
        tick();
        for (int c = 0; c < 6; c++) begin
            setIn(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
            if (c == 0) begin
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (occA[k] !== 4'd0) begin errors++; $display("FAIL flush_occ[%0d]: got %0d want 0", k, occA[k]); end
                end
                checks++;
                if (od[1] !== 16'hDEAD) begin errors++; $display("FAIL flush_data: got %h want dead", od[1]); end
            end
            checks++;
            if (ov[1] !== 1'b0) begin errors++; $display("FAIL flush_ghost c%0d: got v=%b d=%h want v=0", c, ov[1], od[1]); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            setIn(1'b1, 1'b0, 1'b0, 1'b1, 16'h0100 + 16'(c), 1'b1);
            tick();
        end
        setIn(1'b0, 1'b0, 1'b0, 1'b1, 16'h01FF, 1'b1);
        tick();
        setIn(1'b1, 1'b0, 1'b0, 1'b1, 16'h00AB, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (occA[k] !== 4'd0 || ov[k] !== 1'b0 || od[k] !== RVA[k]) begin
                errors++; $display("FAIL midreset[%0d]: got occ=%0d v=%b d=%h want 0 0 %h", k, occA[k], ov[k], od[k], RVA[k]);
            end
        end
        tick();
        for (int c = 1; c <= 3; c++) begin
            setIn(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
            if (c == 1) begin
                checks++;
                if (ov[0] !== 1'b1 || od[0] !== 16'h00AB) begin
                    errors++; $display("FAIL midreset_d1 c%0d: got v=%b d=%h want v=1 d=00ab", c, ov[0], od[0]);
                end
            end
            checks++;
            if (c < 3 && ov[2] !== 1'b0) begin
                errors++; $display("FAIL midreset_early c%0d: got v=%b want 0", c, ov[2]);
            end else if (c == 3 && (ov[2] !== 1'b1 || od[2] !== 16'h00AB)) begin
                errors++; $display("FAIL midreset_latency: got v=%b d=%h want v=1 d=00ab", ov[2], od[2]);
            end
            tick();
        end
    endtask

`ifdef PIPE_SKID_EN
    task automatic test_skid();
        setIn(1'b1, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0);
        tick();
        setIn(1'b1, 1'b0, 1'b0, 1'b1, 16'h000B, 1'b0);
        checks++;
        if (ir[0] !== 1'b1) begin errors++; $display("FAIL skid_accept: got %b want 1", ir[0]); end
        tick();
        setIn(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (occA[0] !== 4'd2 || ir[0] !== 1'b0) begin
            errors++; $display("FAIL skid_full: got occ=%0d rdy=%b want 2 0", occA[0], ir[0]);
        end
        checks++;
        if (ov[0] !== 1'b1 || od[0] !== 16'h000A) begin errors++; $display("FAIL skid_first: got v=%b d=%h want 1 000a", ov[0], od[0]); end
        tick();
        setIn(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (ov[0] !== 1'b1 || od[0] !== 16'h000B || ir[0] !== 1'b1) begin
            errors++; $display("FAIL skid_second: got v=%b d=%h rdy=%b want 1 000b 1", ov[0], od[0], ir[0]);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            setIn($urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 3) != 0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ir[k] !== eIr[k]) begin errors++; $display("FAIL rnd_in_ready[%0d] c%0d: got %b want %b", k, c, ir[k], eIr[k]); end
                checks++;
                if (ov[k] !== eOv[k]) begin errors++; $display("FAIL rnd_out_valid[%0d] c%0d: got %b want %b", k, c, ov[k], eOv[k]); end
                checks++;
                if (od[k] !== mOut[k]) begin errors++; $display("FAIL rnd_out_data[%0d] c%0d: got %h want %h", k, c, od[k], mOut[k]); end
                checks++;
                if (occA[k] !== 4'(mCnt[k])) begin errors++; $display("FAIL rnd_occ[%0d] c%0d: got %0d want %0d", k, c, occA[k], mCnt[k]); end
            end
            tick();
        end
    endtask

    initial begin
        resetn = 1'b0; stall = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0; inData = '0;
        for (int k = 0; k < 3; k++) begin
            mCnt[k] = 0;
            mOut[k] = RVA[k];
        end
        @(negedge clk);
        test_reset();
        test_back_to_back();
        drain();
        test_backpressure();
        drain();
        test_stall();
        drain();
        test_flush();
        drain();
        test_reset_mid();
        drain();
`ifdef PIPE_SKID_EN
        test_skid();
        drain();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
